red_pitaya_bus_init: RTL and testbench

- System-bus initiator: the requesting end of the sys_addr/sys_wdata/sys_wen/sys_ren/sys_rdata/sys_ack/sys_err bus that housekeeping and other register blocks answer.
- Accepts single read/write commands on a valid/ready port and issues exactly one one-cycle strobe per command.
- Waits for sys_ack, with an optional timeout, then returns rdata and status on a valid/ready response port.
- Used by on-chip sequencers (self-test, boot config loader) to reach register blocks without the PS.

---
 rtl/red_pitaya_bus_pkg.sv | 22 ++
 rtl/red_pitaya_bus_tmo.sv | 35 +++
 rtl/red_pitaya_bus_init.sv | 131 +++++++++++++
 tb/tb_red_pitaya_bus_init.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_bus_pkg.sv
// Shared definitions for the red_pitaya system-bus initiator: FSM encoding, bus widths,
// default timeout length and a configuration sanity helper.
package red_pitaya_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRB = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int BUS_AW      = 32;
  localparam int BUS_DW      = 32;
  localparam int TMO_CYC_DEF = 255;

  // The counter must reach TMO_CYC-1 without wrapping.
  function automatic bit tmo_cfg_ok(input int tmo, input int tw);
    return (tmo >= 2) && (tmo <= 65535) && (tw >= 1) && (tw < 31) &&
           ((longint'(1) << tw) > longint'(tmo));
  endfunction

endpackage

// File: rtl/red_pitaya_bus_tmo.sv
// Missing-ack timeout counter for red_pitaya_bus_init; only built when
// RED_PITAYA_BUS_INIT_TIMEOUT_EN is defined.
`ifdef RED_PITAYA_BUS_INIT_TIMEOUT_EN
module red_pitaya_bus_tmo
  import red_pitaya_bus_pkg::*;
#(
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter int TW      = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TW-1:0] LAST = TW'(TMO_CYC - 1);

  logic [TW-1:0] r_cnt;

  // Saturates at the threshold so a stalled count never wraps back into range.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired_o = (r_cnt == LAST);

endmodule
`endif

// File: rtl/red_pitaya_bus_init.sv
// red_pitaya_bus_init: turns valid/ready commands into one-cycle sys_wen/sys_ren strobes and returns the ack.
// Define RED_PITAYA_BUS_INIT_TIMEOUT_EN to abandon a transfer TMO_CYC cycles after the strobe.
module red_pitaya_bus_init
  import red_pitaya_bus_pkg::*;
#(
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter int TW      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wr_i,
  input  logic [BUS_AW-1:0] cmd_addr_i,
  input  logic [BUS_DW-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BUS_DW-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_tmo_o,
  output logic              busy_o,
  output logic [BUS_AW-1:0] sys_addr,
  output logic [BUS_DW-1:0] sys_wdata,
  output logic              sys_wen,
  output logic              sys_ren,
  input  logic [BUS_DW-1:0] sys_rdata,
  input  logic              sys_err,
  input  logic              sys_ack
);

  state_t            r_state, w_state_nxt;
  logic              r_wr, w_wr_nxt;
  logic [BUS_AW-1:0] r_addr, w_addr_nxt;
  logic [BUS_DW-1:0] r_wdata, w_wdata_nxt;
  logic [BUS_DW-1:0] r_rdata, w_rdata_nxt;
  logic              r_err, w_err_nxt;
  logic              r_tmo, w_tmo_nxt;
  logic              w_expired;

  // Out-of-range TMO_CYC/TW shows up as g_bad_tmo_cfg in the elaborated hierarchy.
  if (!tmo_cfg_ok(TMO_CYC, TW)) begin : g_bad_tmo_cfg
  end

`ifdef RED_PITAYA_BUS_INIT_TIMEOUT_EN
  red_pitaya_bus_tmo #(
    .TMO_CYC (TMO_CYC),
    .TW      (TW)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (r_state == STRB),
    .en_i      (r_state == WAIT),
    .expired_o (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr    <= w_wr_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    w_tmo_nxt   = r_tmo;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid_i) begin
          w_wr_nxt    = cmd_wr_i;
          w_addr_nxt  = cmd_addr_i;
          w_wdata_nxt = cmd_wr_i ? cmd_wdata_i : '0;
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b0;
          w_tmo_nxt   = 1'b0;
          w_state_nxt = STRB;
        end
      end
      STRB: w_state_nxt = WAIT;
      // An ack on the threshold cycle takes precedence over the timeout.
      WAIT: begin
        if (sys_ack) begin
          w_rdata_nxt = r_wr ? '0 : sys_rdata;
          w_err_nxt   = sys_err;
          w_state_nxt = RESP;
        end else if (w_expired) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b0;
          w_tmo_nxt   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign cmd_ready_o = (r_state == IDLE) && !rst_i;
  assign rsp_valid_o = (r_state == RESP);
  assign busy_o      = (r_state != IDLE);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign rsp_tmo_o   = r_tmo;
  assign sys_addr    = r_addr;
  assign sys_wdata   = r_wdata;
  assign sys_wen     = (r_state == STRB) && r_wr;
  assign sys_ren     = (r_state == STRB) && !r_wr;

endmodule

// File: tb/tb_red_pitaya_bus_init.sv
// Self-checking bench for red_pitaya_bus_init: a model register responder acks one cycle after
// each strobe; expected responses are queued at command time and popped when rsp_valid_o rises.
`timescale 1ns/1ps
module tb_red_pitaya_bus_init;

  localparam int          TMO        = 8;
  localparam logic [31:0] FORCE_DATA = 32'h0BAD_CAFE;
  localparam logic [31:0] HK_ADDR    = 32'h4010_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_wr_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_tmo_o;
  logic        busy_o;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  red_pitaya_bus_init #(.TMO_CYC(TMO), .TW(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_wr_i    (cmd_wr_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_tmo_o   (rsp_tmo_o),
    .busy_o      (busy_o),
    .sys_addr    (sys_addr),
    .sys_wdata   (sys_wdata),
    .sys_wen     (sys_wen),
    .sys_ren     (sys_ren),
    .sys_rdata   (sys_rdata),
    .sys_err     (sys_err),
    .sys_ack     (sys_ack)
  );

  always #5 clk_i = ~clk_i;

  int nPass = 0;
  int nChecks = 0;
  int cyc = 0;
  int renCount = 0;
  int wenCount = 0;
  rsp_t expQ[$];

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (sys_ren === 1'b1) renCount <= renCount + 1;
    if (sys_wen === 1'b1) wenCount <= wenCount + 1;
  end

  // Model responder: registered ack one cycle after a strobe, small register file behind it.
  logic [31:0] mem [0:63] = '{default: 32'h0};
  logic        respNoAck = 1'b0;
  logic        respErrMode = 1'b0;
  logic        forceAck = 1'b0;
  logic        rAck = 1'b0;
  logic        rErr = 1'b0;
  logic [31:0] rData = 32'h0;

  always @(posedge clk_i) begin
    rAck <= 1'b0;
    rErr <= 1'b0;
    if ((sys_ren === 1'b1 || sys_wen === 1'b1) && !respNoAck) begin
      rAck <= 1'b1;
      rErr <= respErrMode;
      if (sys_wen === 1'b1) mem[sys_addr[7:2]] <= sys_wdata;
      else if (respErrMode) rData <= 32'hDEAD_BEEF;
      else if (sys_addr == HK_ADDR) rData <= 32'h0000_0001;
      else rData <= mem[sys_addr[7:2]];
    end
  end

  assign sys_ack   = rAck | forceAck;
  assign sys_err   = rErr;
  assign sys_rdata = forceAck ? FORCE_DATA : rData;

  function automatic rsp_t mkRsp(input logic [31:0] rdata, input logic err, input logic tmo);
    rsp_t r;
    r.rdata = rdata;
    r.err   = err;
    r.tmo   = tmo;
    return r;
  endfunction

  task automatic checkEq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Offers a command at a negedge and returns at the negedge of the strobe cycle.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input rsp_t exp, output int acceptCyc);
    int n = 0;
    cmd_wr_i    = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_valid_i = 1'b1;
    while (cmd_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    acceptCyc = cyc;
    checkEq("cmd_accept", {127'b0, cmd_ready_o}, 128'd1);
    expQ.push_back(exp);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  // Waits (bounded) for a response, compares it with the scoreboard head and consumes it.
  task automatic checkOutput(input string tag, input int budget, output int seenCyc);
    rsp_t exp;
    int n = 0;
    while (rsp_valid_o !== 1'b1 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    seenCyc = cyc;
    checkEq({tag, "_valid"}, {127'b0, rsp_valid_o}, 128'd1);
    if (expQ.size() == 0) begin
      checkEq({tag, "_queue"}, 128'd0, 128'd1);
    end else begin
      exp = expQ.pop_front();
      if (rsp_valid_o === 1'b1) begin
        checkEq({tag, "_rdata"}, {96'b0, rsp_rdata_o}, {96'b0, exp.rdata});
        checkEq({tag, "_err"},   {127'b0, rsp_err_o},  {127'b0, exp.err});
        checkEq({tag, "_tmo"},   {127'b0, rsp_tmo_o},  {127'b0, exp.tmo});
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c0, seen, r0, w0;
    logic ok;

    // Reset state, sampled while rst_i is still high.
    repeat (2) @(negedge clk_i);
    checkEq("reset_outputs",
            {25'b0, cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o, busy_o,
             sys_addr, sys_wdata, sys_wen, sys_ren}, 128'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkEq("idle_ready", {127'b0, cmd_ready_o}, 128'd1);

    // Read of the housekeeping ID word; wdata must be forced to 0.
    r0 = renCount; w0 = wenCount;
    applyStimulus(1'b0, HK_ADDR, 32'hFFFF_FFFF, mkRsp(32'h1, 1'b0, 1'b0), c0);
    checkEq("rd_strobe", {126'b0, sys_ren, sys_wen}, 128'b10);
    checkEq("rd_addr", {96'b0, sys_addr}, {96'b0, HK_ADDR});
    checkEq("rd_wdata_zero", {96'b0, sys_wdata}, 128'd0);
    checkOutput("rd", 20, seen);
    checkEq("rd_latency", 128'(seen - c0), 128'd3);
    checkEq("rd_valid_drop", {127'b0, rsp_valid_o}, 128'd0);
    checkEq("rd_pulses", {64'b0, 32'(renCount - r0), 32'(wenCount - w0)}, {64'b0, 32'd1, 32'd0});

    // Write 0xA5 to 0x30; wdata/addr must hold through WAIT.
    r0 = renCount; w0 = wenCount;
    applyStimulus(1'b1, 32'h30, 32'hA5, mkRsp(32'h0, 1'b0, 1'b0), c0);
    checkEq("wr_strobe", {126'b0, sys_ren, sys_wen}, 128'b01);
    ok = 1'b1;
    for (int i = 0; i < 10 && rsp_valid_o !== 1'b1; i++) begin
      if (sys_wdata !== 32'hA5 || sys_addr !== 32'h30) ok = 1'b0;
      @(negedge clk_i);
    end
    checkEq("wr_hold", {127'b0, ok}, 128'd1);
    checkOutput("wr", 20, seen);
    checkEq("wr_model_reg", {96'b0, mem[12]}, 128'hA5);
    checkEq("wr_pulses", {64'b0, 32'(renCount - r0), 32'(wenCount - w0)}, {64'b0, 32'd0, 32'd1});
    applyStimulus(1'b0, 32'h30, 32'h0, mkRsp(32'hA5, 1'b0, 1'b0), c0);
    checkOutput("rdback", 20, seen);

    // Bus error on a read, then a clean read must clear the status.
    respErrMode = 1'b1;
    applyStimulus(1'b0, HK_ADDR, 32'h0, mkRsp(32'hDEAD_BEEF, 1'b1, 1'b0), c0);
    checkOutput("err", 20, seen);
    respErrMode = 1'b0;
    applyStimulus(1'b0, HK_ADDR, 32'h0, mkRsp(32'h1, 1'b0, 1'b0), c0);
    checkOutput("clean", 20, seen);

    // Back-pressure: response held for 5 cycles while a new command waits.
    applyStimulus(1'b0, HK_ADDR, 32'h0, mkRsp(32'h1, 1'b0, 1'b0), c0);
    for (int i = 0; i < 10 && rsp_valid_o !== 1'b1; i++) @(negedge clk_i);
    cmd_wr_i = 1'b1; cmd_addr_i = 32'h34; cmd_wdata_i = 32'h5A; cmd_valid_i = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      if (cmd_ready_o !== 1'b0 || sys_ren !== 1'b0 || sys_wen !== 1'b0 ||
          rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h1 || rsp_err_o !== 1'b0) ok = 1'b0;
    end
    checkEq("bp_hold", {127'b0, ok}, 128'd1);
    checkOutput("bp", 2, seen);
    checkEq("bp_resume", {127'b0, cmd_ready_o}, 128'd1);
    expQ.push_back(mkRsp(32'h0, 1'b0, 1'b0));
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    checkEq("bp_wr_strobe", {126'b0, sys_ren, sys_wen}, 128'b01);
    checkOutput("bp_wr", 20, seen);
    checkEq("bp_model_reg", {96'b0, mem[13]}, 128'h5A);

    // Missing ack.
    respNoAck = 1'b1;
`ifdef RED_PITAYA_BUS_INIT_TIMEOUT_EN
    applyStimulus(1'b0, 32'h44, 32'h0, mkRsp(32'h0, 1'b0, 1'b1), c0);
    checkOutput("tmo", 40, seen);
    checkEq("tmo_latency", 128'(seen - c0), 128'(TMO + 2));
    // Ack on the threshold cycle wins over the timeout.
    applyStimulus(1'b0, 32'h48, 32'h0, mkRsp(FORCE_DATA, 1'b0, 1'b0), c0);
    for (int i = 0; i < 40 && cyc < c0 + TMO + 1; i++) @(negedge clk_i);
    checkEq("tie_waiting", {126'b0, busy_o, rsp_valid_o}, 128'b10);
    forceAck = 1'b1;
    @(negedge clk_i);
    forceAck = 1'b0;
    checkOutput("tie", 2, seen);
`else
    applyStimulus(1'b0, 32'h44, 32'h0, mkRsp(FORCE_DATA, 1'b0, 1'b0), c0);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b1 || rsp_tmo_o !== 1'b0) ok = 1'b0;
    end
    checkEq("no_tmo_wait", {127'b0, ok}, 128'd1);
    forceAck = 1'b1;
    @(negedge clk_i);
    forceAck = 1'b0;
    checkOutput("late_ack", 2, seen);
`endif
    // Spurious ack in IDLE is ignored.
    forceAck = 1'b1;
    @(negedge clk_i);
    forceAck = 1'b0;
    @(negedge clk_i);
    checkEq("idle_spurious", {125'b0, busy_o, rsp_valid_o, cmd_ready_o}, 128'b001);

    // Reset during WAIT, then a late ack.
    applyStimulus(1'b0, 32'h50, 32'h0, mkRsp(32'h0, 1'b0, 1'b0), c0);
    @(negedge clk_i);
    checkEq("mid_busy", {127'b0, busy_o}, 128'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkEq("mid_reset_outputs",
            {25'b0, cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o, busy_o,
             sys_addr, sys_wdata, sys_wen, sys_ren}, 128'd0);
    rst_i = 1'b0;
    void'(expQ.pop_back());
    forceAck = 1'b1;
    @(negedge clk_i);
    forceAck = 1'b0;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) ok = 1'b0;
    end
    checkEq("mid_late_ack", {127'b0, ok}, 128'd1);
    respNoAck = 1'b0;

    // Recovery read.
    applyStimulus(1'b0, HK_ADDR, 32'h0, mkRsp(32'h1, 1'b0, 1'b0), c0);
    checkOutput("recover", 20, seen);
    checkEq("recover_latency", 128'(seen - c0), 128'd3);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
